// File: rtl/vga_display_pipe.sv
// Parametrised VGA timing generator with a latency-matched delay line for an
// external renderer and a built-in test-pattern source (bars, solid, grid).
module vga_display_pipe #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 24,
    parameter int unsigned H_SYNC     = 40,
    parameter int unsigned H_BP       = 128,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 9,
    parameter int unsigned V_SYNC     = 3,
    parameter int unsigned V_BP       = 28,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b0,
    parameter int unsigned COLOR_BITS = 2,
    parameter int unsigned PIPE_LAT   = 1,
    parameter int unsigned FRAME_W    = 8,
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned X_W       = $clog2(H_TOTAL),
    localparam int unsigned Y_W       = $clog2(V_TOTAL),
    localparam int unsigned C_W       = 3 * COLOR_BITS
) (
    input  logic               px_clk,
    input  logic               reset,
    input  logic [1:0]         source_sel,
    input  logic [C_W-1:0]     solid_color,
    input  logic [C_W-1:0]     pix_in,
    output logic [X_W-1:0]     x_px,
    output logic [Y_W-1:0]     y_px,
    output logic               activevideo,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic [C_W-1:0]     rgb_out,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam int unsigned BC_W  = $clog2(BAR_W + 1);

    typedef struct packed {
        logic           hs;
        logic           vs;
        logic           av;
        logic [C_W-1:0] pat;
        logic [1:0]     mode;
    } stage_t;

    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [BC_W-1:0]    r_bar_cnt;
    logic [2:0]         r_bar_idx;
    logic [1:0]         r_mode;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [C_W-1:0]     r_rgb;
    logic               r_hsync;
    logic               r_vsync;

    logic               w_x_last;
    logic               w_y_last;
    logic               w_frame_wrap;
    logic               w_grid;
    logic [C_W-1:0]     w_pat;
    stage_t             w_s0;
    stage_t             w_sd;

    assign w_x_last     = (r_x == X_W'(H_TOTAL - 1));
    assign w_y_last     = (r_y == Y_W'(V_TOTAL - 1));
    assign w_frame_wrap = w_x_last && w_y_last;

    // Raster counters, bar sub-counter, mode latch and frame counter
    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_bar_cnt   <= '0;
            r_bar_idx   <= '0;
            r_mode      <= 2'd0;
            r_frame_cnt <= '0;
        end else begin
            if (w_x_last) begin
                r_x       <= '0;
                r_bar_cnt <= '0;
                r_bar_idx <= '0;
                r_y       <= w_y_last ? '0 : r_y + Y_W'(1);
            end else begin
                r_x <= r_x + X_W'(1);
                if (r_bar_cnt == BC_W'(BAR_W - 1)) begin
                    r_bar_cnt <= '0;
                    r_bar_idx <= r_bar_idx + 3'd1;
                end else begin
                    r_bar_cnt <= r_bar_cnt + BC_W'(1);
                end
            end
            if (w_frame_wrap) begin
                r_mode      <= source_sel;
                r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end
        end
    end

    assign x_px        = r_x;
    assign y_px        = r_y;
    assign activevideo = (r_x < X_W'(H_ACTIVE)) && (r_y < Y_W'(V_ACTIVE));
    assign frame_start = (r_x == '0) && (r_y == '0);
    assign frame_cnt   = r_frame_cnt;

    assign w_grid = ((32'(r_x) & 32'hF) == 32'd0) || ((32'(r_y) & 32'hF) == 32'd0);

    // Stage-0 pattern colour for the latched mode
    always_comb begin
        w_pat = '0;
        case (r_mode)
            2'd1:    w_pat = {{COLOR_BITS{r_bar_idx[2]}}, {COLOR_BITS{r_bar_idx[1]}},
                              {COLOR_BITS{r_bar_idx[0]}}};
            2'd2:    w_pat = solid_color;
            2'd3:    w_pat = w_grid ? '1 : '0;
            default: w_pat = '0;
        endcase
    end

    always_comb begin
        w_s0      = '0;
        w_s0.hs   = (r_x >= X_W'(H_ACTIVE + H_FP)) && (r_x < X_W'(H_ACTIVE + H_FP + H_SYNC));
        w_s0.vs   = (r_y >= Y_W'(V_ACTIVE + V_FP)) && (r_y < Y_W'(V_ACTIVE + V_FP + V_SYNC));
        w_s0.av   = activevideo;
        w_s0.pat  = w_pat;
        w_s0.mode = r_mode;
    end

    // Delay line matching renderer latency; flushed to blank/inactive on reset
    generate
        if (PIPE_LAT == 0) begin : g_no_dly
            assign w_sd = w_s0;
        end else begin : g_dly
            stage_t r_dly [PIPE_LAT];
            always_ff @(posedge px_clk) begin
                if (reset) begin
                    for (int i = 0; i < int'(PIPE_LAT); i++) r_dly[i] <= '0;
                end else begin
                    r_dly[0] <= w_s0;
                    for (int i = 1; i < int'(PIPE_LAT); i++) r_dly[i] <= r_dly[i-1];
                end
            end
            assign w_sd = r_dly[PIPE_LAT-1];
        end
    endgenerate

    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_rgb   <= '0;
            r_hsync <= ~HSYNC_POL;
            r_vsync <= ~VSYNC_POL;
        end else begin
            r_rgb   <= w_sd.av ? ((w_sd.mode == 2'd0) ? pix_in : w_sd.pat) : '0;
            r_hsync <= w_sd.hs ? HSYNC_POL : ~HSYNC_POL;
            r_vsync <= w_sd.vs ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    assign rgb_out = r_rgb;
    assign hsync   = r_hsync;
    assign vsync   = r_vsync;

endmodule

// File: doc/vga_display_pipe.md
Name: vga_display_pipe

Overview:
- Parametrised successor to the fixed-mode VGA top. Combines a configurable timing generator, a latency-compensating delay line and an internal test-pattern source.
- Drives a pixel renderer with coordinates and accepts its colour after a fixed PIPE_LAT cycles. Delays sync/blank by the same amount so the outputs stay aligned.
- Source selection (renderer or one of three test patterns) changes only on a frame boundary.

Parameters:
- H_ACTIVE, 640, visible pixels per line (must be divisible by 8)
- H_FP, 24, horizontal front porch
- H_SYNC, 40, horizontal sync width
- H_BP, 128, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 9, vertical front porch
- V_SYNC, 3, vertical sync width
- V_BP, 28, vertical back porch
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- COLOR_BITS, 2, bits per colour channel
- PIPE_LAT, 1, renderer latency in cycles (legal range 0..8)
- FRAME_W, 8, frame counter width

Ports:
- px_clk in 1: pixel clock
- reset in 1: synchronous active-high reset
- source_sel in 2: 0 = renderer, 1 = colour bars, 2 = solid, 3 = grid
- solid_color in 3*COLOR_BITS: colour used when the solid pattern is selected
- pix_in in 3*COLOR_BITS: renderer colour, {R,G,B}
- x_px out clog2(H_TOTAL): current horizontal counter value
- y_px out clog2(V_TOTAL): current vertical counter value
- activevideo out 1: x_px < H_ACTIVE and y_px < V_ACTIVE
- frame_start out 1: one-cycle pulse while x_px==0 and y_px==0
- hsync out 1: delayed horizontal sync
- vsync out 1: delayed vertical sync
- rgb_out out 3*COLOR_BITS: delayed, blanked colour output
- frame_cnt out FRAME_W: completed-frame count

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 832); V_TOTAL defined the same way (default 520).
- Counters:
  - x_px counts 0..H_TOTAL-1, then wraps to 0.
  - y_px increments on each x wrap and wraps to 0 after V_TOTAL-1.
  - x_px, y_px, activevideo and frame_start are combinational from the counter registers (stage 0).
- Raw sync at stage 0:
  - hsync_raw active when H_ACTIVE+H_FP <= x_px < H_ACTIVE+H_FP+H_SYNC.
  - vsync_raw uses the same rule on y_px with the V parameters.
- Renderer contract: pix_in presented at cycle t+PIPE_LAT belongs to the coordinate output at cycle t.
- Test patterns are computed at stage 0 from the counters:
  - Colour bars: bar index b = 0..7 from a sub-counter that advances every H_ACTIVE/8 pixels (no divider). Colour = {R=b[2],G=b[1],B=b[0]}, each bit replicated to COLOR_BITS.
  - Solid: solid_color.
  - Grid: all-ones when x_px[3:0]==0 or y_px[3:0]==0, otherwise zero.
- Delay line: hsync_raw, vsync_raw, activevideo, the pattern colour and the latched mode are delayed by PIPE_LAT stages.
- Output stage (registered):
  - Colour mux selects pix_in when the delayed mode is 0, otherwise the delayed pattern colour.
  - rgb_out = selected colour when delayed activevideo is 1, otherwise 0.
  - hsync and vsync are driven at their polarity parameters.
  - Total latency from counters to outputs: PIPE_LAT+1 cycles.
- Mode latch:
  - source_sel is sampled into mode_q only on the cycle the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Mid-frame changes of source_sel have no effect on the current frame.
- frame_cnt increments on the same wrap event and wraps modulo 2^FRAME_W.
- Reset (synchronous) clears:
  - counters to (0,0), so frame_start is high on the first cycle after reset;
  - mode_q to 0 and frame_cnt to 0;
  - all delay stages to blank with sync inactive;
  - rgb_out to 0, and hsync/vsync to their inactive levels (!HSYNC_POL, !VSYNC_POL).
- Reset mid-frame:
  - Immediately restarts at (0,0).
  - No partial sync pulse is emitted after reset, because the delay line is flushed to inactive.
- PIPE_LAT=0: the delay line degenerates to wires; only the output register remains (latency 1).

Test Plan:
- Default params; reset for 2 cycles, release. Required response:
  - frame_start high on the first cycle;
  - hsync low for 40 cycles starting when x_px==664 (output lags by PIPE_LAT+1 = 2 cycles);
  - vsync low for 3 lines starting at y_px==489;
  - frame_start pulses every 832*520 cycles.
- Small params (H 16/2/2/4, V 8/1/1/2, PIPE_LAT=3); pix_in = x_px delayed 3 cycles. Required response: rgb_out equals x value 4 cycles after the coordinate; rgb_out=0 for x>=16 or y>=8.
- source_sel=1, COLOR_BITS=2, H_ACTIVE=16. Required response: rgb_out walks 000000, 000011, 001100, 001111 … 111111 with each bar 2 pixels wide.
- Set source_sel 0→2 at mid-frame, solid_color=6'b110000. Required response: renderer colour persists until the next frame_start; from then every active pixel is 110000 after the pipeline delay.
- Grid mode. Required response: active pixels with x%16==0 or y%16==0 are 111111, all others 000000.
- Assert reset mid-frame with FRAME_W=2 after 3 frames, then run 2 more frames. Required response:
  - at reset: counters=0, frame_cnt=0, hsync/vsync inactive;
  - over the 2 frames: frame_cnt goes 0→1→2;
  - separately, running 4 frames from reset shows frame_cnt wrapping 3→0.
